// File: rtl/mac_pipe_sat.sv
// Two-stage pipelined signed multiply-accumulate with clamping accumulator,
// valid-tagged output and a sticky saturation flag.
module mac_pipe_sat #(
    parameter int unsigned INW  = 16,
    parameter int unsigned OUTW = 48
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [INW-1:0]  in0,
    input  logic [INW-1:0]  in1,
    input  logic            valid_input,
    input  logic            clear_acc,
    output logic [OUTW-1:0] out,
    output logic            valid_out,
    output logic            sat
);

    localparam int unsigned PW = 2 * INW;
    localparam int unsigned SW = OUTW + 1;

    localparam logic signed [OUTW-1:0] ACC_MAX = {1'b0, {(OUTW-1){1'b1}}};
    localparam logic signed [OUTW-1:0] ACC_MIN = {1'b1, {(OUTW-1){1'b0}}};

    // A clear-and-load product must always fit in the accumulator.
    if (OUTW < PW) begin : g_width_check
        $error("mac_pipe_sat: OUTW must be at least 2*INW");
    end

    logic signed [PW-1:0]   prod_c;
    logic signed [PW-1:0]   prod1;
    logic                   v1;
    logic                   c1;

    logic signed [OUTW-1:0] acc;
    logic signed [OUTW-1:0] acc_nxt_c;
    logic                   sat_nxt_c;
    logic signed [SW-1:0]   sum_c;

    // Full-precision signed product; no truncation.
    assign prod_c = PW'($signed(in0)) * PW'($signed(in1));

    // Stage 1: register product and tags; operands are ignored when not valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod1 <= '0;
            v1    <= 1'b0;
            c1    <= 1'b0;
        end else begin
            if (valid_input) begin
                prod1 <= prod_c;
            end
            v1 <= valid_input;
            c1 <= clear_acc;
        end
    end

    // One guard bit is enough to detect overflow of a single addition.
    assign sum_c = SW'(acc) + SW'(prod1);

    // Stage 2 next-state: clear-and-load, saturating accumulate, pure clear, hold.
    always_comb begin
        acc_nxt_c = acc;
        sat_nxt_c = sat;
        unique case ({v1, c1})
            2'b11: begin
                acc_nxt_c = OUTW'(prod1);
                sat_nxt_c = 1'b0;
            end
            2'b10: begin
                if (sum_c[SW-1] != sum_c[SW-2]) begin
                    acc_nxt_c = sum_c[SW-1] ? ACC_MIN : ACC_MAX;
                    sat_nxt_c = 1'b1;
                end else begin
                    acc_nxt_c = sum_c[OUTW-1:0];
                end
            end
            2'b01: begin
                acc_nxt_c = '0;
                sat_nxt_c = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            sat       <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            acc       <= acc_nxt_c;
            sat       <= sat_nxt_c;
            valid_out <= v1;
        end
    end

    assign out = acc;

endmodule

// File: tb/tb_mac_pipe_sat.sv
// Directed-vector and reference-model bench for mac_pipe_sat (INW=16, OUTW=32).
module tb_mac_pipe_sat;

    localparam int unsigned INW  = 16;
    localparam int unsigned OUTW = 32;
    localparam int          NTBL = 17;
    localparam int          NRND = 10000;
    localparam longint      MAXV = 64'sd2147483647;
    localparam longint      MINV = -64'sd2147483648;

    typedef struct {
        logic signed [INW-1:0] a;
        logic signed [INW-1:0] b;
        logic                  v;
        logic                  c;
        longint                eout;
        logic                  evo;
        logic                  esat;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [INW-1:0]  in0 = '0;
    logic [INW-1:0]  in1 = '0;
    logic            valid_input = 1'b0;
    logic            clear_acc = 1'b0;
    logic [OUTW-1:0] out;
    logic            valid_out;
    logic            sat;

    int n_cmp = 0;
    int n_err = 0;

    vec_t tbl [NTBL];
    vec_t pend [$];

    mac_pipe_sat #(.INW(INW), .OUTW(OUTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in0         (in0),
        .in1         (in1),
        .valid_input (valid_input),
        .clear_acc   (clear_acc),
        .out         (out),
        .valid_out   (valid_out),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic signed [INW-1:0] a, input logic signed [INW-1:0] b,
                         input logic v, input logic c);
        in0         = a;
        in1         = b;
        valid_input = v;
        clear_acc   = c;
    endtask

    task automatic chk_outs(input string tag, input longint eo, input logic evo, input logic esat);
        chk({tag, " out"}, longint'($signed(out)), eo);
        chk({tag, " valid_out"}, longint'(valid_out), longint'(evo));
        chk({tag, " sat"}, longint'(sat), longint'(esat));
    endtask

    initial begin
        longint m_acc;
        logic   m_sat;
        vec_t   r;

        // Directed stream: expected values are the state after each row reaches stage 2.
        tbl[0]  = '{16'sd2,     16'sd3,     1'b1, 1'b1, 64'sd6,           1'b1, 1'b0};
        tbl[1]  = '{16'sd4,     16'sd5,     1'b1, 1'b0, 64'sd26,          1'b1, 1'b0};
        tbl[2]  = '{-16'sd1,    16'sd7,     1'b1, 1'b0, 64'sd19,          1'b1, 1'b0};
        tbl[3]  = '{16'sd10,    16'sd10,    1'b1, 1'b1, 64'sd100,         1'b1, 1'b0};
        tbl[4]  = '{16'sd123,   16'sd456,   1'b0, 1'b0, 64'sd100,         1'b0, 1'b0};
        tbl[5]  = '{16'sh7fff,  16'sh7fff,  1'b1, 1'b1, 64'sd1073676289,  1'b1, 1'b0};
        tbl[6]  = '{16'sh7fff,  16'sh7fff,  1'b1, 1'b0, 64'sd2147352578,  1'b1, 1'b0};
        tbl[7]  = '{16'sh7fff,  16'sh7fff,  1'b1, 1'b0, 64'sd2147483647,  1'b1, 1'b1};
        tbl[8]  = '{-16'sd1,    16'sd1,     1'b1, 1'b0, 64'sd2147483646,  1'b1, 1'b1};
        tbl[9]  = '{16'sh8000,  16'sh7fff,  1'b1, 1'b1, -64'sd1073709056, 1'b1, 1'b0};
        tbl[10] = '{16'sh8000,  16'sh7fff,  1'b1, 1'b0, -64'sd2147418112, 1'b1, 1'b0};
        tbl[11] = '{16'sh8000,  16'sh7fff,  1'b1, 1'b0, -64'sd2147483648, 1'b1, 1'b1};
        tbl[12] = '{16'sd777,   -16'sd5,    1'b0, 1'b0, -64'sd2147483648, 1'b0, 1'b1};
        tbl[13] = '{16'sd999,   16'sd999,   1'b0, 1'b1, 64'sd0,           1'b0, 1'b0};
        tbl[14] = '{16'sh8000,  16'sh8000,  1'b1, 1'b1, 64'sd1073741824,  1'b1, 1'b0};
        tbl[15] = '{16'sh8000,  16'sh8000,  1'b1, 1'b0, 64'sd2147483647,  1'b1, 1'b1};
        tbl[16] = '{16'sd3,     -16'sd4,    1'b1, 1'b1, -64'sd12,         1'b1, 1'b0};

        // Reset state with junk on the inputs.
        drive(16'sd55, 16'sd66, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk_outs("reset", 64'sd0, 1'b0, 1'b0);
        drive(16'sd0, 16'sd0, 1'b0, 1'b0);
        reset = 1'b1;

        // Row j is driven at iteration j and checked at iteration j+2.
        for (int i = 0; i <= NTBL + 1; i++) begin
            @(negedge clk);
            if (i >= 2) chk_outs($sformatf("row%0d", i - 2), tbl[i-2].eout, tbl[i-2].evo, tbl[i-2].esat);
            if (i < NTBL) drive(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].c);
            else          drive(16'sd0, 16'sd0, 1'b0, 1'b0);
        end

        // Reset mid-stream: saturate, then reset with a fourth product still in flight.
        drive(16'sh7fff, 16'sh7fff, 1'b1, 1'b1);
        @(negedge clk) drive(16'sh7fff, 16'sh7fff, 1'b1, 1'b0);
        @(negedge clk) drive(16'sh7fff, 16'sh7fff, 1'b1, 1'b0);
        @(negedge clk) drive(16'sd5, 16'sd5, 1'b1, 1'b0);
        @(negedge clk);
        chk_outs("pre_reset", 64'sd2147483647, 1'b1, 1'b1);
        drive(16'sd0, 16'sd0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk_outs("async_reset", 64'sd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_outs("post_release", 64'sd0, 1'b0, 1'b0);
        drive(16'sd2, 16'sd3, 1'b1, 1'b0);
        @(negedge clk) drive(16'sd0, 16'sd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("first_after_reset", 64'sd6, 1'b1, 1'b0);
        @(negedge clk);
        chk_outs("hold_after_reset", 64'sd6, 1'b0, 1'b0);

        // Random stream against a saturating reference model.
        m_acc = 0;
        m_sat = 1'b0;
        for (int i = 0; i <= NRND + 1; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                r = pend.pop_front();
                if (r.v && r.c) begin
                    m_acc = longint'(r.a) * longint'(r.b);
                    m_sat = 1'b0;
                end else if (r.v) begin
                    m_acc = m_acc + longint'(r.a) * longint'(r.b);
                    if (m_acc > MAXV) begin
                        m_acc = MAXV;
                        m_sat = 1'b1;
                    end else if (m_acc < MINV) begin
                        m_acc = MINV;
                        m_sat = 1'b1;
                    end
                end else if (r.c) begin
                    m_acc = 0;
                    m_sat = 1'b0;
                end
                chk_outs($sformatf("rnd%0d", i - 2), m_acc, r.v, m_sat);
            end
            if (i < NRND) begin
                r.v = ($urandom_range(0, 7) != 0) || (i == 0);
                r.c = ($urandom_range(0, 15) == 0) || (i == 0);
                case ($urandom_range(0, 3))
                    0: begin
                        r.a = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
                        r.b = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
                    end
                    1: begin
                        r.a = INW'($signed($urandom_range(0, 200)) - 100);
                        r.b = INW'($signed($urandom_range(0, 200)) - 100);
                    end
                    default: begin
                        r.a = INW'($urandom);
                        r.b = INW'($urandom);
                    end
                endcase
                pend.push_back(r);
                drive(r.a, r.b, r.v, r.c);
            end else begin
                drive(16'sd0, 16'sd0, 1'b0, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
